instr_mem_writer: RTL and testbench
===================================

Name: instr_mem_writer

Overview:
- Write-side counterpart of the byte-addressed instruction memory read port.
- Takes a byte stream from the loader link (UART RX side) with a valid/ready handshake.
- Packs each 4 bytes into a 32-bit instruction word, first byte in the MSB (big-endian, matching the read-side word assembly).
- Writes each word into the 8-bit-wide instruction memory as 4 consecutive byte writes, at addresses 0, 4, 8, … until a HALT word is loaded or memory is full.

Parameters:
- bitsDir, 32, width of the memory address and of the instruction word.
- MEM_SIZE, 128, instruction memory size in bytes; must be a multiple of 4.
- HALT_WORD, 32'hFFFFFFFF, instruction value that ends the load.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load at address 0.
- rx_data  in  8  incoming program byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  writer accepts a byte this cycle.
- mem_we  out  1  byte write strobe to the instruction memory.
- mem_addr  out  bitsDir  byte address of the write.
- mem_wdata  out  8  byte to write.
- busy  out  1  a load is in progress.
- done  out  1  load finished; held high until the next start.
- overflow  out  1  load ended because memory was full, not on HALT; held with done.
- word_count  out  bitsDir  number of words fully written, including HALT.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs go to 0; state goes to IDLE.
  - Internal word register, byte index and base address are cleared.
  - A reset mid-load discards any partial word. Bytes already written stay in memory.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - rx_ready = 0, busy = 0.
  - On start: base = 0, word_count = 0, byte index = 0, clear done and overflow, go to RECV.
- RECV:
  - busy = 1, rx_ready = 1.
  - A byte is accepted only when rx_valid and rx_ready are both high on a rising edge.
  - Accepted byte k (k = 0..3) goes to word bits [31-8k -: 8].
  - After byte 3 is accepted, go to WRITE on the next cycle. rx_ready drops in the cycle after byte 3 is accepted.
- WRITE:
  - Exactly 4 cycles with rx_ready = 0 and mem_we = 1.
  - Beat j (j = 0..3): mem_addr = base + j, mem_wdata = word[31-8j -: 8].
  - After beat 3, word_count increments.
  - If word == HALT_WORD: go to DONE with done = 1, overflow = 0.
  - Else if base + 4 == MEM_SIZE: go to DONE with done = 1, overflow = 1.
  - Else: base += 4, go to RECV.
- DONE:
  - busy = 0, rx_ready = 0; done and overflow hold.
  - start restarts a load exactly as from IDLE.
- mem_we is 0 outside WRITE; mem_addr and mem_wdata are don't-care when mem_we = 0.
- start while busy is ignored.
- Latency: the first memory write happens 1 cycle after the 4th byte handshake. A word takes at least 4 + 4 = 8 cycles.
- Address arithmetic is bitsDir-bit unsigned. base never exceeds MEM_SIZE-4.
- Memory samples the write on the rising edge. The read port samples on the falling edge, so a word is readable no earlier than the negedge after its last write beat.

Optional Feature:
- Macro: IMEM_WR_CHECKSUM_EN.
- Defined:
  - Extra output checksum[7:0]: running XOR of every accepted byte since start, cleared on start and on reset.
  - Final value is valid while done = 1.
- Undefined: no checksum port and no checksum logic.

Decomposition:
- Shared package imem_pkg:
  - FSM state typedef (IDLE/RECV/WRITE/DONE).
  - MEM_SIZE and HALT_WORD defaults.
  - Byte-lane constants, shared with the read side.
- One natural sub-module: instr_word_packer.
  - 4-byte big-endian shift/assemble register with byte index and full flag.
  - The FSM and write sequencing stay in instr_mem_writer.

Test Plan:
- Single word then HALT:
  - Stimulus: start, then bytes 8'h20,8'h01,8'h00,8'h05, then 4×8'hFF.
  - Required: writes (0,20)(1,01)(2,00)(3,05)(4..7,FF); done = 1, overflow = 0, word_count = 2.
  - Read side: word at address 0 reads 32'h20010005.
- Valid gaps and backpressure:
  - Stimulus: rx_valid toggled randomly.
  - Required: only handshaken bytes are packed; rx_ready = 0 for all 4 WRITE cycles; no byte lost or duplicated.
- Memory full:
  - Stimulus: 32 non-HALT words with MEM_SIZE = 128.
  - Required: last write at address 127; done = 1, overflow = 1, word_count = 32; rx_ready stays 0 afterwards.
- Reset mid-load:
  - Stimulus: rst_n low after 2 bytes of word 1.
  - Required: all outputs 0, state IDLE. A fresh start then writes again from address 0.
- start while busy / restart from DONE:
  - Stimulus: start pulse during RECV, then start pulse in DONE.
  - Required: the first start has no effect; the second clears done and word_count and loads again at address 0.
- Checksum, with IMEM_WR_CHECKSUM_EN defined:
  - Stimulus: bytes 01,02,04,08 then HALT.
  - Required: checksum = 8'h0F at done.

Source files
------------

// File: rtl/instr_mem_writer_pkg.sv
// Shared definitions for the instruction memory write and read sides.
// Package name: imem_pkg.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } imem_state_t;

    localparam int          BYTE_W         = 8;
    localparam int          WORD_W         = 32;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          MEM_SIZE_DEF   = 128;
    localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;

    // Byte lanes of a big-endian word: lane 0 is the most significant byte.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    function automatic logic [BYTE_W-1:0] word_lane(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        lane);
        logic [BYTE_W-1:0] b;
        b = word[31:24];
        case (lane)
            LANE_B0: b = word[31:24];
            LANE_B1: b = word[23:16];
            LANE_B2: b = word[15:8];
            LANE_B3: b = word[7:0];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/instr_mem_writer_if.sv
// Loader byte stream (valid/ready) plus byte-wide instruction memory write bus.
// master: loader/memory side; slave: the writer.
interface instr_mem_writer_if #(
    parameter int bitsDir = 32
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               mem_we;
    logic [bitsDir-1:0] mem_addr;
    logic [7:0]         mem_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/instr_mem_writer_packer.sv
// instr_word_packer: assembles 4 accepted bytes into a big-endian word.
// The first byte lands in the MSB lane; full is held until the writer clears it.
module instr_word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              full,
    output logic              last
);
    logic [WORD_W-1:0] word_q;
    logic [1:0]        idx_q;
    logic              full_q;

    assign word = word_q;
    assign full = full_q;
    // High in the cycle the fourth byte of a word is being accepted.
    assign last = load && (idx_q == LANE_B3);

    // Byte index, assembled word and full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (clear) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (load) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (idx_q == 2'(k)) begin
                    word_q[WORD_W-BYTE_W*(k+1) +: BYTE_W] <= byte_in;
                end
            end
            idx_q <= idx_q + 2'd1;
            if (idx_q == LANE_B3) begin
                full_q <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/instr_mem_writer.sv
// instr_mem_writer: loads a program byte stream into the byte-wide instruction
// memory, one 32-bit word (4 byte writes) at a time, until HALT or memory full.
// Optional macro IMEM_WR_CHECKSUM_EN adds a running XOR checksum output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start after reset
// ST_RECV  | accepting bytes of the current word
// ST_WRITE | four byte-write beats of the assembled word
// ST_DONE  | load finished (HALT or memory full), flags held
module instr_mem_writer
    import imem_pkg::*;
#(
    parameter int          bitsDir   = 32,
    parameter int          MEM_SIZE  = MEM_SIZE_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    instr_mem_writer_if.slave  bus,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [bitsDir-1:0] word_count
`ifdef IMEM_WR_CHECKSUM_EN
    ,
    output logic [7:0]         checksum
`endif
);
    localparam logic [bitsDir-1:0] LAST_BASE = bitsDir'(MEM_SIZE - BYTES_PER_WORD);
    localparam logic [bitsDir-1:0] WORD_STEP = bitsDir'(BYTES_PER_WORD);

    imem_state_t        state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [bitsDir-1:0] base_q, base_d;
    logic [bitsDir-1:0] count_q, count_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               rx_ready;
    logic               mem_we;
    logic               accept;
    logic               load_start;
    logic               pk_clear;
    logic [WORD_W-1:0]  pk_word;
    logic               pk_full;
    logic               pk_last;

    assign accept = bus.rx_valid && rx_ready;

    instr_word_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (pk_clear),
        .load    (accept),
        .byte_in (bus.rx_data),
        .word    (pk_word),
        .full    (pk_full),
        .last    (pk_last)
    );

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = base_q + bitsDir'(beat_q);
    assign bus.mem_wdata = word_lane(pk_word, beat_q);
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign word_count    = count_q;

    // State and write-sequencing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, handshake and write-strobe decode.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        count_d    = count_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        rx_ready   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        load_start = 1'b0;
        pk_clear   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_start = 1'b1;
                    pk_clear   = 1'b1;
                    base_d     = '0;
                    count_d    = '0;
                    beat_d     = '0;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = ST_RECV;
                end
            end

            ST_RECV: begin
                busy     = 1'b1;
                rx_ready = !pk_full;
                if (pk_last) begin
                    beat_d  = '0;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                beat_d = beat_q + 2'd1;
                if (beat_q == LANE_B3) begin
                    // Word fully written; release the packer for the next word.
                    count_d  = count_q + 1'b1;
                    pk_clear = 1'b1;
                    if (pk_word == HALT_WORD) begin
                        done_d  = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if (base_q == LAST_BASE) begin
                        done_d  = 1'b1;
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        base_d  = base_q + WORD_STEP;
                        state_d = ST_RECV;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef IMEM_WR_CHECKSUM_EN
    logic [7:0] csum_q;

    assign checksum = csum_q;

    // Running XOR of every accepted byte since the last start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (load_start) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q ^ bus.rx_data;
        end
    end
`endif
endmodule

// File: tb/tb_instr_mem_writer.sv
// Directed testbench for instr_mem_writer (MEM_SIZE = 128, HALT = FFFFFFFF).
module tb_instr_mem_writer;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] word_count;
`ifdef IMEM_WR_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    instr_mem_writer_if #(.bitsDir(32)) bus ();

    instr_mem_writer #(
        .bitsDir   (32),
        .MEM_SIZE  (128),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
`ifdef IMEM_WR_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] mem [0:127];
    int         wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         wr_cyc_q  [$];
    logic [7:0] hs_q      [$];
    int         hs_cyc_q  [$];
    int         ready_during_we = 0;
    int         we_cycles = 0;

    always @(negedge clk) cyc = cyc + 1;

    // Memory model and bus monitors, sampled at the active edge.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (bus.mem_addr < 32'd128) mem[bus.mem_addr[6:0]] = bus.mem_wdata;
            wr_addr_q.push_back(int'(bus.mem_addr));
            wr_data_q.push_back(bus.mem_wdata);
            wr_cyc_q.push_back(cyc);
            we_cycles++;
            if (bus.rx_ready === 1'b1) ready_during_we++;
        end
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            hs_q.push_back(bus.rx_data);
            hs_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        hs_q.delete();
        hs_cyc_q.delete();
        ready_during_we = 0;
        we_cycles = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout got rx_ready=%b exp 1 byte=%h", bus.rx_ready, b);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(t[31:24]);
            t = t << 8;
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout got done=%b exp 1", done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, overflow, bus.rx_ready, bus.mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {busy, done, overflow, bus.rx_ready, bus.mem_we});
        end
        checks++;
        if (word_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_word_count got %0d exp 0", word_count);
        end
        checks++;
        if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_mem_bus got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b ready=%b exp 0 0", busy, bus.rx_ready);
        end
    endtask

    task automatic test_single_halt();
        logic [7:0] exp_d [8];
        exp_d = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        clear_logs();
        pulse_start();
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        wait_done(50);
        checks++;
        if (wr_addr_q.size() !== 8) begin
            errors++;
            $display("FAIL single_write_count got %0d exp 8", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wr_addr_q[i] !== i || wr_data_q[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL single_write_%0d got (%0d,%h) exp (%0d,%h)", i, wr_addr_q[i], wr_data_q[i], i, exp_d[i]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_flags got done=%b ovf=%b busy=%b exp 1 0 0", done, overflow, busy);
        end
        checks++;
        if (word_count !== 32'd2) begin
            errors++;
            $display("FAIL single_word_count got %0d exp 2", word_count);
        end
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h2001_0005) begin
            errors++;
            $display("FAIL single_read_word got %h exp 20010005", {mem[0], mem[1], mem[2], mem[3]});
        end
        checks++;
        if (hs_cyc_q.size() < 4 || wr_cyc_q.size() < 1 || wr_cyc_q[0] !== hs_cyc_q[3] + 1) begin
            errors++;
            $display("FAIL single_latency got first write %0d cycles after 4th byte exp 1",
                     (wr_cyc_q.size() > 0 && hs_cyc_q.size() > 3) ? wr_cyc_q[0] - hs_cyc_q[3] : -1);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] bytes [12];
        int         gaps  [12];
        int         bad;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF};
        gaps  = '{0, 3, 1, 0, 2, 5, 0, 1, 0, 0, 4, 0};
        clear_logs();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'hA5;
            repeat (gaps[i]) @(negedge clk);
            send_byte(bytes[i]);
        end
        wait_done(50);
        checks++;
        if (hs_q.size() !== 12) begin
            errors++;
            $display("FAIL gaps_handshake_count got %0d exp 12", hs_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 12; i++) if (hs_q[i] !== bytes[i]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL gaps_handshake_bytes got %0d wrong bytes exp 0", bad);
            end
        end
        checks++;
        if (ready_during_we !== 0 || we_cycles !== 12) begin
            errors++;
            $display("FAIL gaps_backpressure got ready_in_write=%0d write_cycles=%0d exp 0 12", ready_during_we, we_cycles);
        end
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h1122_3344 ||
            {mem[4], mem[5], mem[6], mem[7]} !== 32'h5566_7788) begin
            errors++;
            $display("FAIL gaps_words got %h %h exp 11223344 55667788",
                     {mem[0], mem[1], mem[2], mem[3]}, {mem[4], mem[5], mem[6], mem[7]});
        end
        checks++;
        if (word_count !== 32'd3 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL gaps_count got %0d ovf=%b exp 3 0", word_count, overflow);
        end
    endtask

    task automatic test_full();
        int bad;
        int n_hs;
        clear_logs();
        pulse_start();
        for (int w = 0; w < 32; w++) begin
            for (int k = 0; k < 4; k++) send_byte(8'(4 * w + k));
        end
        wait_done(50);
        checks++;
        if (wr_addr_q.size() !== 128 || wr_addr_q[$] !== 127 || wr_data_q[$] !== 8'd127) begin
            errors++;
            $display("FAIL full_last_write got n=%0d addr=%0d exp n=128 addr=127", wr_addr_q.size(),
                     wr_addr_q.size() > 0 ? wr_addr_q[$] : -1);
        end
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== 8'(i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_contents got %0d wrong bytes exp 0", bad);
        end
        checks++;
        if (done !== 1'b1 || overflow !== 1'b1 || word_count !== 32'd32) begin
            errors++;
            $display("FAIL full_flags got done=%b ovf=%b count=%0d exp 1 1 32", done, overflow, word_count);
        end
        n_hs = hs_q.size();
        bus.rx_data  = 8'h3C;
        bus.rx_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rx_ready !== 1'b0) bad++;
        end
        bus.rx_valid = 1'b0;
        checks++;
        if (bad !== 0 || hs_q.size() !== n_hs) begin
            errors++;
            $display("FAIL full_ready_after got ready_cycles=%0d extra_bytes=%0d exp 0 0", bad, hs_q.size() - n_hs);
        end
    endtask

    task automatic test_start_busy_restart();
        clear_logs();
        pulse_start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        pulse_start();
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_word(32'hFFFF_FFFF);
        wait_done(50);
        checks++;
        if (wr_addr_q.size() < 4 || wr_addr_q[0] !== 0 ||
            {wr_data_q[0], wr_data_q[1], wr_data_q[2], wr_data_q[3]} !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL busy_start_ignored got n=%0d exp first word DEADBEEF at 0", wr_addr_q.size());
        end
        checks++;
        if (word_count !== 32'd2) begin
            errors++;
            $display("FAIL busy_start_count got %0d exp 2", word_count);
        end
        clear_logs();
        pulse_start();
        checks++;
        if (done !== 1'b0 || overflow !== 1'b0 || word_count !== 32'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear got done=%b ovf=%b count=%0d busy=%b exp 0 0 0 1", done, overflow, word_count, busy);
        end
        send_word(32'h0A0B_0C0D);
        send_word(32'hFFFF_FFFF);
        wait_done(50);
        checks++;
        if (wr_addr_q.size() !== 8 || wr_addr_q[0] !== 0 || wr_data_q[0] !== 8'h0A || word_count !== 32'd2) begin
            errors++;
            $display("FAIL restart_load got n=%0d count=%0d exp 8 writes from addr 0, count 2", wr_addr_q.size(), word_count);
        end
    endtask

    task automatic test_reset_midload();
        clear_logs();
        pulse_start();
        send_word(32'hAABB_CCDD);
        send_byte(8'h01);
        send_byte(8'h02);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, overflow, bus.rx_ready, bus.mem_we} !== 5'b0 || word_count !== 32'd0) begin
            errors++;
            $display("FAIL midload_reset got flags=%b count=%0d exp 00000 0",
                     {busy, done, overflow, bus.rx_ready, bus.mem_we}, word_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        pulse_start();
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        wait_done(50);
        checks++;
        if (wr_addr_q.size() !== 8 || wr_addr_q[0] !== 0 || {mem[0], mem[1], mem[2], mem[3]} !== 32'h1234_5678) begin
            errors++;
            $display("FAIL midload_fresh got n=%0d word0=%h exp 8 12345678", wr_addr_q.size(), {mem[0], mem[1], mem[2], mem[3]});
        end
        checks++;
        if (word_count !== 32'd2 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midload_count got %0d ovf=%b exp 2 0", word_count, overflow);
        end
    endtask

`ifdef IMEM_WR_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        checks++;
        if (checksum !== 8'h00) begin
            errors++;
            $display("FAIL checksum_clear got %h exp 00", checksum);
        end
        send_word(32'h0102_0408);
        send_word(32'hFFFF_FFFF);
        wait_done(50);
        checks++;
        if (checksum !== 8'h0F) begin
            errors++;
            $display("FAIL checksum_value got %h exp 0F", checksum);
        end
    endtask
`endif

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        start        = 1'b0;
        rst_n        = 1'b0;
        test_reset();
        test_single_halt();
        test_gaps();
        test_full();
        test_start_busy_restart();
        test_reset_midload();
`ifdef IMEM_WR_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
